// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EX->MEM bundle, waits for the data_sram response, extends load data.
// Forwarding to ID (mem_bypass) is built only when MEM_BYPASS_EN is defined.
`timescale 1ns/1ps
module mem_stage #(
    parameter int CANCEL_W = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                EX_to_MEM,
    input  logic [193:0]        EX_to_MEM_zip,
    input  logic [46:0]         EX_except_zip,
    output logic                MEM_allowin,
    input  logic                WB_allowin,
    output logic                MEM_to_WB,
    output logic [187:0]        MEM_to_WB_zip,
    output logic [46:0]         MEM_except_zip,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    input  logic                flush,
    output logic                MEM_block,
    output logic [38:0]         mem_bypass,
    output logic [1:0]          dbg_state,
    output logic [CANCEL_W-1:0] dbg_cancel_cnt
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        gr_we;
        logic [4:0]  waddr;
        logic [31:0] alu_res;
        logic        res_from_mem;
        logic        mem_we;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        req_issued;
        logic        tlbrd;
        logic        tlbwr;
        logic        tlbfill;
        logic        invtlb;
        logic        cacop;
        logic        csr_re;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic [13:0] csr_num;
    } ex_bundle_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e              state_q, state_d;
    ex_bundle_t          ex_q, ex_d, ex_in;
    logic [46:0]         exc_q, exc_d;
    logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;
    logic [31:0]         rdata_buf_q, rdata_buf_d;
    logic                buf_v_q, buf_v_d;

    logic        rsp_mine, rsp_drop, ready_go, accept, cnt_inc, cnt_dec;
    logic [31:0] ld_word, ld_ext, rf_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        unused_mem_we;

    assign ex_in         = ex_bundle_t'(EX_to_MEM_zip);
    assign unused_mem_we = ex_q.mem_we;

    // Handshake: a bundle moves EX->MEM when EX_to_MEM & MEM_allowin, and MEM->WB when MEM_to_WB;
    // MEM_allowin never depends on EX_to_MEM, and MEM_to_WB already includes WB_allowin.
    always_comb begin
        rsp_mine    = data_sram_data_ok & (cancel_cnt_q == '0) & (state_q == S_WAIT);
        rsp_drop    = data_sram_data_ok & (cancel_cnt_q != '0);
        ready_go    = (state_q == S_RUN) | (state_q == S_HOLD) | rsp_mine;
        MEM_allowin = ~ex_q.valid | (ready_go & WB_allowin);
        MEM_to_WB   = ex_q.valid & ready_go & WB_allowin & ~flush;
        accept      = EX_to_MEM & MEM_allowin;
        cnt_inc     = flush & (state_q == S_WAIT) & ~rsp_mine;
        cnt_dec     = rsp_drop;
    end

    always_comb begin
        state_d      = state_q;
        ex_d         = ex_q;
        exc_d        = exc_q;
        rdata_buf_d  = rdata_buf_q;
        buf_v_d      = buf_v_q;
        cancel_cnt_d = cancel_cnt_q;
        if (accept) begin
            ex_d       = ex_in;
            ex_d.valid = ex_in.valid & ~flush;
            exc_d      = EX_except_zip;
            buf_v_d    = 1'b0;
            if (!ex_d.valid)          state_d = S_IDLE;
            else if (ex_in.req_issued) state_d = S_WAIT;
            else                       state_d = S_RUN;
        end else if (MEM_allowin) begin
            ex_d.valid = 1'b0;
            buf_v_d    = 1'b0;
            state_d    = S_IDLE;
        end else if (rsp_mine) begin
            rdata_buf_d = data_sram_rdata;
            buf_v_d     = 1'b1;
            state_d     = S_HOLD;
        end
        if (flush) begin
            ex_d.valid = 1'b0;
            buf_v_d    = 1'b0;
            state_d    = S_IDLE;
        end
        if (cnt_inc && !cnt_dec)      cancel_cnt_d = cancel_cnt_q + CANCEL_W'(1);
        else if (cnt_dec && !cnt_inc) cancel_cnt_d = cancel_cnt_q - CANCEL_W'(1);
    end

    // Load data: buffered copy once parked in HOLD, otherwise the live response.
    always_comb begin
        ld_word = buf_v_q ? rdata_buf_q : data_sram_rdata;
        case (ex_q.alu_res[1:0])
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ex_q.alu_res[1] ? ld_word[31:16] : ld_word[15:0];
        case (ex_q.mem_size)
            2'b00:   ld_ext = {{24{~ex_q.mem_unsigned & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~ex_q.mem_unsigned & ld_half[15]}}, ld_half};
            default: ld_ext = ld_word;
        endcase
        rf_wdata = ex_q.res_from_mem ? ld_ext : ex_q.alu_res;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            ex_q         <= '0;
            exc_q        <= '0;
            cancel_cnt_q <= '0;
            rdata_buf_q  <= '0;
            buf_v_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ex_q         <= ex_d;
            exc_q        <= exc_d;
            cancel_cnt_q <= cancel_cnt_d;
            rdata_buf_q  <= rdata_buf_d;
            buf_v_q      <= buf_v_d;
        end
    end

    // Except layout: [46] ertn, [45:32] exception flags, [31:0] bad address.
    assign MEM_except_zip = exc_q;
    assign MEM_block      = ex_q.valid & ((|exc_q[46:32]) | ex_q.tlbwr | ex_q.tlbfill
                                          | ex_q.invtlb | ex_q.cacop);
    assign MEM_to_WB_zip  = {ex_q.valid, ex_q.pc, ex_q.ir, ex_q.gr_we, ex_q.waddr, rf_wdata,
                             ex_q.tlbrd, ex_q.tlbwr, ex_q.tlbfill, ex_q.invtlb, ex_q.cacop,
                             ex_q.csr_re, ex_q.csr_we, ex_q.csr_wmask, ex_q.csr_wvalue, ex_q.csr_num};

`ifdef MEM_BYPASS_EN
    assign mem_bypass = {ex_q.valid & ex_q.gr_we, state_q == S_WAIT, ex_q.waddr, rf_wdata};
`else
    assign mem_bypass = '0;
`endif

    assign dbg_state      = state_q;
    assign dbg_cancel_cnt = cancel_cnt_q;

    // A further cancelled response beyond the counter range cannot be tracked.
    assert property (@(posedge clk) disable iff (!resetn)
                     !(cnt_inc && !cnt_dec && (&cancel_cnt_q)));

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: transaction model with an expected queue checked every cycle,
// plus hand-computed literal expectations for loads, flush cancellation and reset.
`timescale 1ns/1ps
module tb_mem_stage;

    logic         clk, resetn, ex_to_mem, wb_allowin, data_ok, flush;
    logic [193:0] ex_zip;
    logic [46:0]  ex_exc;
    logic [31:0]  rdata;
    logic         mem_allowin, mem_to_wb, mem_block;
    logic [187:0] wb_zip;
    logic [46:0]  wb_exc;
    logic [38:0]  mem_bypass;
    logic [1:0]   dbg_state_unused;
    logic [1:0]   cancel_cnt;

    logic [187:0] exp_q[$];
    logic [46:0]  exp_exc_q[$];
    int           n_checks = 0;
    int           n_fail = 0;

    logic [193:0] b;
    logic [193:0] b2;
    logic [46:0]  e;

    mem_stage #(.CANCEL_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .EX_to_MEM(ex_to_mem), .EX_to_MEM_zip(ex_zip), .EX_except_zip(ex_exc),
        .MEM_allowin(mem_allowin), .WB_allowin(wb_allowin),
        .MEM_to_WB(mem_to_wb), .MEM_to_WB_zip(wb_zip), .MEM_except_zip(wb_exc),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata), .flush(flush),
        .MEM_block(mem_block), .mem_bypass(mem_bypass),
        .dbg_state(dbg_state_unused), .dbg_cancel_cnt(cancel_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [193:0] mk_ex(input logic [31:0] pc, input logic [31:0] ir,
            input logic gr_we, input logic [4:0] waddr, input logic [31:0] alu, input logic ld,
            input logic st, input logic [1:0] size, input logic uns, input logic req,
            input logic [6:0] flags);
        return {1'b1, pc, ir, gr_we, waddr, alu, ld, st, size, uns, req, flags, ~pc, ir ^ pc, pc[15:2]};
    endfunction

    // WB sees the EX bundle minus the memory-control fields, with the result inserted after waddr.
    function automatic logic [187:0] mk_wb(input logic [193:0] ex, input logic [31:0] rf);
        return {ex[193:123], rf, ex[84:0]};
    endfunction

    function automatic logic [31:0] ext_model(input logic [31:0] word, input logic [1:0] addr,
            input logic [1:0] size, input logic uns);
        int unsigned nbytes, offset, v, span;
        nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        offset = (nbytes == 4) ? 0 : (32'(addr) / nbytes) * nbytes;
        v = word >> (8 * offset);
        if (nbytes < 4) begin
            span = 32'd1 << (8 * nbytes);
            v = v % span;
            if (!uns && v >= span / 2) v = v - span;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        ex_to_mem = 1'b0;
        data_ok   = 1'b0;
        flush     = 1'b0;
        rdata     = $urandom;
        ex_zip    = {2'b10, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        ex_exc    = {15'($urandom), $urandom};
    endtask

    task automatic send(input logic [193:0] bb, input logic [46:0] ee);
        ex_to_mem = 1'b1;
        ex_zip    = bb;
        ex_exc    = ee;
    endtask

    task automatic expect_wb(input logic [193:0] bb, input logic [31:0] rf, input logic [46:0] ee);
        exp_q.push_back(mk_wb(bb, rf));
        exp_exc_q.push_back(ee);
    endtask

    // Every cycle: outputs sampled at the falling edge, each WB transfer popped from the model.
    task automatic sample();
        @(negedge clk);
        if (resetn && mem_to_wb) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wb: got transfer %0h, expected none", wb_zip);
            end else begin
                check("wb_zip", 256'(wb_zip), 256'(exp_q.pop_front()));
                check("wb_except", 256'(wb_exc), 256'(exp_exc_q.pop_front()));
            end
        end
    endtask

    initial begin
        resetn = 1'b0; wb_allowin = 1'b1; ex_to_mem = 1'b0; data_ok = 1'b0; flush = 1'b0;
        rdata = '0; ex_zip = '0; ex_exc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_allowin", 256'(mem_allowin), 256'h1);
        check("rst_to_wb", 256'(mem_to_wb), 256'h0);
        check("rst_wb_zip", 256'(wb_zip), 256'h0);
        check("rst_except", 256'(wb_exc), 256'h0);
        check("rst_block", 256'(mem_block), 256'h0);
        check("rst_bypass", 256'(mem_bypass), 256'h0);
        check("rst_cancel", 256'(cancel_cnt), 256'h0);
        resetn = 1'b1;

        check("model_ldb", 256'(ext_model(32'h80AA_BBCC, 2'd3, 2'b00, 1'b0)), 256'hFFFF_FF80);
        check("model_ldhu", 256'(ext_model(32'hF00D_1234, 2'd2, 2'b01, 1'b1)), 256'h0000_F00D);

        // ld.b from lane 3, response in the first MEM cycle
        b = mk_ex(32'h1C00_0100, 32'h2800_0000, 1'b1, 5'd4, 32'h1000_0003, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 7'd0);
        cyc(); send(b, '0); expect_wb(b, ext_model(32'h80AA_BBCC, 2'd3, 2'b00, 1'b0), '0); sample();
        check("t1_allowin_idle", 256'(mem_allowin), 256'h1);
        cyc(); data_ok = 1'b1; rdata = 32'h80AA_BBCC; sample();
        check("t1_to_wb", 256'(mem_to_wb), 256'h1);
        check("t1_rf_wdata", 256'(wb_zip[116:85]), 256'hFFFF_FF80);
        check("t1_block", 256'(mem_block), 256'h0);
`ifdef MEM_BYPASS_EN
        check("t1_load_pending", 256'(mem_bypass[37]), 256'h1);
`else
        check("t1_bypass_off", 256'(mem_bypass), 256'h0);
`endif

        // ld.hu upper half, response three cycles late
        b = mk_ex(32'h1C00_0104, 32'h2A40_0000, 1'b1, 5'd5, 32'h2000_0002, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 7'd0);
        cyc(); send(b, '0); expect_wb(b, ext_model(32'hF00D_1234, 2'd2, 2'b01, 1'b1), '0); sample();
        check("t2_allowin_accept", 256'(mem_allowin), 256'h1);
        for (int i = 0; i < 3; i++) begin
            cyc(); sample();
            check("t2_wait_allowin", 256'(mem_allowin), 256'h0);
            check("t2_wait_to_wb", 256'(mem_to_wb), 256'h0);
        end
        cyc(); data_ok = 1'b1; rdata = 32'hF00D_1234; sample();
        check("t2_to_wb", 256'(mem_to_wb), 256'h1);
        check("t2_rf_wdata", 256'(wb_zip[116:85]), 256'h0000_F00D);

        // ld.h with WB stalled: response must be held while the bus changes
        b = mk_ex(32'h1C00_0108, 32'h2840_0000, 1'b1, 5'd6, 32'h3000_0000, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 7'd0);
        cyc(); send(b, '0); expect_wb(b, 32'hFFFF_8001, '0); sample();
        cyc(); wb_allowin = 1'b0; data_ok = 1'b1; rdata = 32'h1234_8001; sample();
        check("hold_to_wb", 256'(mem_to_wb), 256'h0);
        check("hold_allowin", 256'(mem_allowin), 256'h0);
        cyc(); sample();
        check("hold_allowin2", 256'(mem_allowin), 256'h0);
        cyc(); wb_allowin = 1'b1; sample();
        check("hold_release", 256'(mem_to_wb), 256'h1);

        // back-to-back ALU ops, then a WB stall on the second
        b  = mk_ex(32'h1C00_0200, 32'h0010_1CE7, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 7'd0);
        b2 = mk_ex(32'h1C00_0204, 32'h0010_2508, 1'b1, 5'd8, 32'h0BAD_F00D, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 7'd0);
        cyc(); send(b, '0); expect_wb(b, 32'hDEAD_BEEF, '0); sample();
        cyc(); send(b2, '0); expect_wb(b2, 32'h0BAD_F00D, '0); sample();
        check("b2b_allowin", 256'(mem_allowin), 256'h1);
        check("b2b_to_wb", 256'(mem_to_wb), 256'h1);
`ifdef MEM_BYPASS_EN
        check("b2b_bypass", 256'(mem_bypass), 256'({1'b1, 1'b0, 5'd7, 32'hDEAD_BEEF}));
`else
        check("b2b_bypass_off", 256'(mem_bypass), 256'h0);
`endif
        cyc(); wb_allowin = 1'b0; sample();
        check("run_stall_allowin", 256'(mem_allowin), 256'h0);
        check("run_stall_to_wb", 256'(mem_to_wb), 256'h0);
        cyc(); wb_allowin = 1'b1; sample();
        check("run_release", 256'(mem_to_wb), 256'h1);

        // st.w still waits for its response; result is the address
        b = mk_ex(32'h1C00_0208, 32'h2980_0000, 1'b0, 5'd0, 32'h4000_0010, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 7'd0);
        cyc(); send(b, '0); expect_wb(b, 32'h4000_0010, '0); sample();
        cyc(); sample();
        check("st_wait", 256'(mem_to_wb), 256'h0);
        cyc(); data_ok = 1'b1; sample();
        check("st_done", 256'(mem_to_wb), 256'h1);

        // flush in WAIT: the late response is dropped, not given to the next load
        b = mk_ex(32'h1C00_0300, 32'h2880_0000, 1'b1, 5'd9, 32'h5000_0000, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 7'd0);
        cyc(); send(b, '0); sample();
        cyc(); flush = 1'b1; sample();
        check("t3_flush_to_wb", 256'(mem_to_wb), 256'h0);
        cyc(); sample();
        check("t3_cancel_cnt", 256'(cancel_cnt), 256'h1);
        check("t3_valid_cleared", 256'(wb_zip[187]), 256'h0);
        check("t3_allowin", 256'(mem_allowin), 256'h1);
        b = mk_ex(32'h1C00_0304, 32'h2A00_0000, 1'b1, 5'd10, 32'h6000_0001, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 7'd0);
        cyc(); data_ok = 1'b1; send(b, '0); expect_wb(b, 32'h0000_0033, '0); sample();
        check("t3_stale_to_wb", 256'(mem_to_wb), 256'h0);
        cyc(); sample();
        check("t3_cnt_drained", 256'(cancel_cnt), 256'h0);
        check("t3_no_misattrib", 256'(mem_to_wb), 256'h0);
        cyc(); data_ok = 1'b1; rdata = 32'h1122_33C4; sample();
        check("t3_real_rsp", 256'(mem_to_wb), 256'h1);

        // flush and response in the same cycle
        b = mk_ex(32'h1C00_0308, 32'h2880_0000, 1'b1, 5'd11, 32'h7000_0004, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 7'd0);
        cyc(); send(b, '0); sample();
        cyc(); flush = 1'b1; data_ok = 1'b1; sample();
        check("t4_to_wb", 256'(mem_to_wb), 256'h0);
        cyc(); sample();
        check("t4_cancel_cnt", 256'(cancel_cnt), 256'h0);
        check("t4_valid", 256'(wb_zip[187]), 256'h0);

        // syscall: blocks EX, passes through with its except bundle
        b = mk_ex(32'h1C00_0400, 32'h002B_0000, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 7'd0);
        e = {15'h0400, 32'h1C00_0400};
        cyc(); send(b, e); expect_wb(b, 32'h0, e); sample();
        cyc(); sample();
        check("t5_block", 256'(mem_block), 256'h1);
        check("t5_to_wb", 256'(mem_to_wb), 256'h1);
        check("t5_except", 256'(wb_exc), 256'({15'h0400, 32'h1C00_0400}));

        // tlbwr also blocks
        b = mk_ex(32'h1C00_0404, 32'h0648_3000, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 7'b0100000);
        cyc(); send(b, '0); expect_wb(b, 32'h0, '0); sample();
        cyc(); sample();
        check("tlbwr_block", 256'(mem_block), 256'h1);

        // reset while WAIT with a cancelled response outstanding
        b = mk_ex(32'h1C00_0500, 32'h2880_0000, 1'b1, 5'd12, 32'h8000_0000, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 7'd0);
        cyc(); send(b, '0); sample();
        cyc(); flush = 1'b1; sample();
        cyc(); send(b, '0); sample();
        cyc();
        check("t6_cnt_before_reset", 256'(cancel_cnt), 256'h1);
        #2 resetn = 1'b0;
        #1;
        check("t6_allowin", 256'(mem_allowin), 256'h1);
        check("t6_wb_zip", 256'(wb_zip), 256'h0);
        check("t6_except", 256'(wb_exc), 256'h0);
        check("t6_cancel", 256'(cancel_cnt), 256'h0);
        check("t6_to_wb", 256'(mem_to_wb), 256'h0);
        sample();
        resetn = 1'b1;
        cyc(); data_ok = 1'b1; sample();
        check("t6_stray_to_wb", 256'(mem_to_wb), 256'h0);
        cyc(); sample();
        check("t6_stray_cnt", 256'(cancel_cnt), 256'h0);

        // add.w after reset: visible on the forwarding path
        b = mk_ex(32'h1C00_0600, 32'h0010_1D8D, 1'b1, 5'd13, 32'h0000_1234, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 7'd0);
        cyc(); send(b, '0); expect_wb(b, 32'h0000_1234, '0); sample();
        cyc(); sample();
`ifdef MEM_BYPASS_EN
        check("t6_bypass_we", 256'(mem_bypass[38]), 256'h1);
`else
        check("t6_bypass_off", 256'(mem_bypass), 256'h0);
`endif
        check("t6_add_to_wb", 256'(mem_to_wb), 256'h1);
        cyc(); sample();

        check("queue_drained", 256'(exp_q.size()), 256'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
